// File: rtl/lcd_timing_pkg.sv
// Shared LCD timing types, widths and the default 800x480 panel timing used by
// both the RGB transmit driver and the DE-mode receiver.
package lcd_timing_pkg;

    localparam int COORD_W = 11;
    localparam int RGB_W   = 24;

    localparam int H_SYNC  = 128;
    localparam int H_BP    = 88;
    localparam int H_ACT   = 800;
    localparam int H_FP    = 40;
    localparam int H_TOTAL = 1056;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_ACT   = 480;
    localparam int V_FP    = 10;
    localparam int V_TOTAL = 525;

    typedef logic [COORD_W-1:0] coord_t;

    localparam coord_t COORD_ZERO = 11'd0;
    localparam coord_t COORD_ONE  = 11'd1;
    localparam coord_t COORD_MAX  = 11'h7FF;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        BLANK  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_t;

    function automatic coord_t coord_inc_sat(input coord_t v);
        return (v == COORD_MAX) ? v : v + COORD_ONE;
    endfunction

endpackage

// File: rtl/lcd_rgb_rx_if.sv
// Coordinate-tagged pixel stream produced by the LCD RGB receiver.
interface lcd_rgb_rx_if;
    import lcd_timing_pkg::*;

    logic             pixel_valid;
    logic [RGB_W-1:0] pixel_data;
    coord_t           pixel_x;
    coord_t           pixel_y;
    logic             frame_start;
    logic             line_end;

    modport master (
        output pixel_valid, pixel_data, pixel_x, pixel_y, frame_start, line_end
    );

    modport slave (
        input pixel_valid, pixel_data, pixel_x, pixel_y, frame_start, line_end
    );

endinterface

// File: rtl/lcd_rx_measure.sv
// Active-resolution measurement and lock tracking: latches line 0 length,
// flags inconsistent frames and updates h_res/v_res/locked at each frame end.
module lcd_rx_measure
    import lcd_timing_pkg::*;
#(
    parameter int LOCK_FRAMES = 2
) (
    input  logic   lcd_pclk,
    input  logic   rst_n,
    input  logic   line_end,
    input  coord_t line_len,
    input  logic   line_sat,
    input  coord_t line_y,
    input  logic   vblank,
    output coord_t h_res,
    output coord_t v_res,
    output logic   locked
);

    localparam logic [4:0] LOCK_TH = 5'(LOCK_FRAMES);

    coord_t     cur_h_r;
    coord_t     h_res_r;
    coord_t     v_res_r;
    logic       frame_bad_r;
    logic       locked_r;
    logic [3:0] match_r;

    coord_t     cur_v_s;
    logic [4:0] match_inc_s;
    logic       mismatch_s;

    // Frame-end comparison terms; line_y holds the last line's row at vblank.
    always_comb begin
        cur_v_s     = line_y + COORD_ONE;
        match_inc_s = {1'b0, match_r} + 5'd1;
        mismatch_s  = frame_bad_r || (cur_h_r != h_res_r) || (cur_v_s != v_res_r);
    end

    // Line-length latch, frame_bad tracking and end-of-frame resolution update.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            cur_h_r     <= COORD_ZERO;
            h_res_r     <= COORD_ZERO;
            v_res_r     <= COORD_ZERO;
            frame_bad_r <= 1'b0;
            locked_r    <= 1'b0;
            match_r     <= 4'd0;
        end else if (vblank) begin
            frame_bad_r <= 1'b0;
            if (mismatch_s) begin
                h_res_r  <= cur_h_r;
                v_res_r  <= cur_v_s;
                match_r  <= 4'd0;
                locked_r <= 1'b0;
            end else begin
                match_r  <= (match_r == 4'hF) ? match_r : match_inc_s[3:0];
                locked_r <= (match_inc_s >= LOCK_TH);
            end
        end else if (line_end) begin
            if (line_y == COORD_ZERO) begin
                cur_h_r     <= line_len;
                frame_bad_r <= frame_bad_r | line_sat;
            end else begin
                frame_bad_r <= frame_bad_r | line_sat | (line_len != cur_h_r);
            end
        end else begin
            frame_bad_r <= frame_bad_r;
        end
    end

    assign h_res  = h_res_r;
    assign v_res  = v_res_r;
    assign locked = locked_r;

endmodule

// File: rtl/lcd_rgb_rx.sv
// DE-mode RGB888 receiver: recovers frame/line structure from DE alone and emits
// a coordinate-tagged pixel stream. LCD_RX_CHECKSUM_EN adds a per-frame pixel sum.
module lcd_rgb_rx
    import lcd_timing_pkg::*;
#(
    parameter int VBLANK_MIN  = 1024,
    parameter int GAP_W       = 16,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             lcd_pclk,
    input  logic             rst_n,
    input  logic             lcd_de,
    input  logic [RGB_W-1:0] lcd_rgb,
    lcd_rgb_rx_if.master     pix,
    output coord_t           h_res,
    output coord_t           v_res,
    output logic             locked
`ifdef LCD_RX_CHECKSUM_EN
    ,
    output logic [31:0]      frame_sum
`endif
);

    localparam logic [GAP_W-1:0] GAP_HIT  = GAP_W'(VBLANK_MIN - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = {GAP_W{1'b1}};
    localparam logic [GAP_W-1:0] GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};

    logic             de_q_r;
    logic             de_d_r;
    logic [RGB_W-1:0] rgb_q_r;
    logic [GAP_W-1:0] gap_r;
    rx_state_t        state_r;
    rx_state_t        state_nxt_s;

    logic             valid_r;
    logic [RGB_W-1:0] data_r;
    coord_t           x_r;
    coord_t           y_r;
    logic             fs_r;
    logic             le_r;

    logic             valid_nxt_s;
    logic             fs_nxt_s;
    logic             le_nxt_s;
    coord_t           x_nxt_s;
    coord_t           y_nxt_s;
    logic             eof_s;
    logic             vblank_hit_s;
    logic             de_rise_s;

    // Input sampling stage; de_d_r gives the previous sample for rise detection.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            de_q_r  <= 1'b0;
            de_d_r  <= 1'b0;
            rgb_q_r <= {RGB_W{1'b0}};
        end else begin
            de_q_r  <= lcd_de;
            de_d_r  <= de_q_r;
            rgb_q_r <= lcd_rgb;
        end
    end

    // Saturating count of consecutive DE-low samples.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            gap_r <= GAP_ZERO;
        end else if (de_q_r) begin
            gap_r <= GAP_ZERO;
        end else if (gap_r != GAP_MAX) begin
            gap_r <= gap_r + GAP_ONE;
        end else begin
            gap_r <= gap_r;
        end
    end

    // The hit fires on the VBLANK_MIN-th consecutive low sample, exactly once per run.
    assign vblank_hit_s = !de_q_r && (gap_r == GAP_HIT);
    assign de_rise_s    = de_q_r && !de_d_r;

    // Receiver state register.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= SEARCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and next pixel outputs; line_end looks ahead at the raw lcd_de.
    always_comb begin
        state_nxt_s = state_r;
        valid_nxt_s = 1'b0;
        fs_nxt_s    = 1'b0;
        le_nxt_s    = 1'b0;
        x_nxt_s     = x_r;
        y_nxt_s     = y_r;
        eof_s       = 1'b0;
        case (state_r)
            SEARCH: begin
                if (vblank_hit_s) begin
                    state_nxt_s = BLANK;
                end else begin
                    state_nxt_s = SEARCH;
                end
            end
            BLANK: begin
                if (de_rise_s) begin
                    state_nxt_s = ACTIVE;
                    valid_nxt_s = 1'b1;
                    fs_nxt_s    = 1'b1;
                    le_nxt_s    = !lcd_de;
                    x_nxt_s     = COORD_ZERO;
                    y_nxt_s     = COORD_ZERO;
                end else begin
                    state_nxt_s = BLANK;
                end
            end
            ACTIVE: begin
                if (vblank_hit_s) begin
                    eof_s       = 1'b1;
                    state_nxt_s = BLANK;
                end else if (de_q_r) begin
                    valid_nxt_s = 1'b1;
                    le_nxt_s    = !lcd_de;
                    if (de_rise_s) begin
                        x_nxt_s = COORD_ZERO;
                        y_nxt_s = coord_inc_sat(y_r);
                    end else begin
                        x_nxt_s = coord_inc_sat(x_r);
                        y_nxt_s = y_r;
                    end
                end else begin
                    state_nxt_s = ACTIVE;
                end
            end
            default: begin
                state_nxt_s = SEARCH;
            end
        endcase
    end

    // Registered pixel stream; data holds its last value between pixels.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= {RGB_W{1'b0}};
            x_r     <= COORD_ZERO;
            y_r     <= COORD_ZERO;
            fs_r    <= 1'b0;
            le_r    <= 1'b0;
        end else begin
            valid_r <= valid_nxt_s;
            data_r  <= valid_nxt_s ? rgb_q_r : data_r;
            x_r     <= x_nxt_s;
            y_r     <= y_nxt_s;
            fs_r    <= fs_nxt_s;
            le_r    <= le_nxt_s;
        end
    end

    assign pix.pixel_valid = valid_r;
    assign pix.pixel_data  = data_r;
    assign pix.pixel_x     = x_r;
    assign pix.pixel_y     = y_r;
    assign pix.frame_start = fs_r;
    assign pix.line_end    = le_r;

    lcd_rx_measure #(
        .LOCK_FRAMES (LOCK_FRAMES)
    ) u_measure (
        .lcd_pclk (lcd_pclk),
        .rst_n    (rst_n),
        .line_end (le_nxt_s),
        .line_len (x_nxt_s + COORD_ONE),
        .line_sat (x_nxt_s == COORD_MAX),
        .line_y   (y_nxt_s),
        .vblank   (eof_s),
        .h_res    (h_res),
        .v_res    (v_res),
        .locked   (locked)
    );

`ifdef LCD_RX_CHECKSUM_EN
    logic [31:0] acc_r;
    logic [31:0] sum_r;

    // Wrapping sum of emitted pixels, restarted at frame_start, latched at frame end.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= 32'd0;
            sum_r <= 32'd0;
        end else begin
            if (fs_r) begin
                acc_r <= {8'd0, data_r};
            end else if (valid_r) begin
                acc_r <= acc_r + {8'd0, data_r};
            end else begin
                acc_r <= acc_r;
            end
            sum_r <= eof_s ? acc_r : sum_r;
        end
    end

    assign frame_sum = sum_r;
`endif

endmodule

// File: tb/tb_lcd_rgb_rx.sv
// Directed bench for lcd_rgb_rx using scaled-down DE timing and a pixel scoreboard.
module tb_lcd_rgb_rx;
    import lcd_timing_pkg::*;

    localparam int VB  = 64;
    localparam int HBL = 24;

    typedef struct packed {
        logic [23:0] data;
        coord_t      x;
        coord_t      y;
        logic        fs;
        logic        le;
    } pix_t;

    logic        lcd_pclk = 1'b0;
    logic        rst_n    = 1'b0;
    logic        lcd_de   = 1'b0;
    logic [23:0] lcd_rgb  = 24'd0;
    coord_t      h_res;
    coord_t      v_res;
    logic        locked;
`ifdef LCD_RX_CHECKSUM_EN
    logic [31:0] frame_sum;
`endif

    lcd_rgb_rx_if pix ();

    lcd_rgb_rx #(
        .VBLANK_MIN  (VB),
        .GAP_W       (16),
        .LOCK_FRAMES (2)
    ) dut (
        .lcd_pclk (lcd_pclk),
        .rst_n    (rst_n),
        .lcd_de   (lcd_de),
        .lcd_rgb  (lcd_rgb),
        .pix      (pix),
        .h_res    (h_res),
        .v_res    (v_res),
        .locked   (locked)
`ifdef LCD_RX_CHECKSUM_EN
        ,
        .frame_sum (frame_sum)
`endif
    );

    always #5 lcd_pclk = ~lcd_pclk;

    pix_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [23:0] data_ctr = 24'd0;
    bit          const_one = 1'b0;
    logic [23:0] last_data = 24'd0;
    bit          seen = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic de, input bit cap, input coord_t x, input coord_t y,
                         input logic fs, input logic le);
        @(negedge lcd_pclk);
        lcd_de   = de;
        lcd_rgb  = const_one ? 24'd1 : data_ctr;
        data_ctr = data_ctr + 24'd1;
        if (cap) exp_q.push_back({lcd_rgb, x, y, fs, le});
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, COORD_ZERO, COORD_ZERO, 1'b0, 1'b0);
    endtask

    task automatic line(input int len, input int y, input bit cap, input bit fs);
        for (int i = 0; i < len; i++)
            drive(1'b1, cap, coord_t'(i), coord_t'(y), fs && (i == 0), i == len - 1);
    endtask

    task automatic frame(input int hact, input int vact, input bit cap, input int short_y = -1);
        for (int l = 0; l < vact; l++) begin
            line((l == short_y) ? hact - 1 : hact, l, cap, l == 0);
            if (l < vact - 1) idle(HBL);
        end
        idle(2 * (hact + HBL) + HBL);
    endtask

    task automatic meas(input string tag, input int h, input int v, input logic lk);
        check({tag, "_h_res"}, 64'(h_res), 64'(h));
        check({tag, "_v_res"}, 64'(v_res), 64'(v));
        check({tag, "_locked"}, 64'(locked), 64'(lk));
    endtask

    // Scoreboard: every emitted pixel must match the next queued expectation.
    always @(negedge lcd_pclk) begin
        pix_t e;
        if (pix.pixel_valid === 1'b1) begin
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_bad++;
                $error("FAIL unexpected_pixel: observed x=%0d y=%0d expected none",
                       pix.pixel_x, pix.pixel_y);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pixel", 64'({pix.pixel_data, pix.pixel_x, pix.pixel_y,
                                    pix.frame_start, pix.line_end}), 64'(e));
            end
            last_data = pix.pixel_data;
            seen      = 1'b1;
        end else if (seen && rst_n) begin
            check("data_hold", 64'(pix.pixel_data), 64'(last_data));
        end
        if (!rst_n) seen = 1'b0;
    end

    initial begin
        repeat (3) @(negedge lcd_pclk);
        check("rst_stream", 64'({pix.pixel_valid, pix.pixel_data, pix.pixel_x, pix.pixel_y,
                                 pix.frame_start, pix.line_end}), 64'd0);
        meas("rst", 0, 0, 1'b0);
        rst_n = 1'b1;

        idle(VB + 8);
        frame(40, 6, 1'b1);  meas("a1", 40, 6, 1'b0);
        frame(40, 6, 1'b1);  meas("a2", 40, 6, 1'b0);
        frame(40, 6, 1'b1);  meas("a3", 40, 6, 1'b1);

        frame(40, 6, 1'b1, 3); meas("short", 40, 6, 1'b0);
        frame(40, 6, 1'b1);  meas("relock1", 40, 6, 1'b0);
        frame(40, 6, 1'b1);  meas("relock2", 40, 6, 1'b1);

        frame(24, 4, 1'b1);  meas("b1", 24, 4, 1'b0);
        frame(24, 4, 1'b1);  meas("b2", 24, 4, 1'b0);
        frame(24, 4, 1'b1);  meas("b3", 24, 4, 1'b1);

        // Gap one below the threshold stays inside the frame.
        line(24, 0, 1'b1, 1'b1); idle(HBL); line(24, 1, 1'b1, 1'b0);
        idle(VB - 1);
        line(24, 2, 1'b1, 1'b0); idle(HBL); line(24, 3, 1'b1, 1'b0);
        idle(2 * 48 + HBL);
        meas("gap_below", 24, 4, 1'b1);

        // Gap at the threshold splits the frame into two 2-line frames.
        line(24, 0, 1'b1, 1'b1); idle(HBL); line(24, 1, 1'b1, 1'b0);
        idle(VB);
        line(24, 0, 1'b1, 1'b1); idle(HBL); line(24, 1, 1'b1, 1'b0);
        meas("gap_at", 24, 2, 1'b0);
        idle(2 * 48 + HBL);
        meas("gap_after", 24, 2, 1'b0);

        // Reset mid-line discards the partial frame and forces a fresh search.
        line(24, 0, 1'b1, 1'b1); idle(HBL);
        for (int i = 0; i < 12; i++)
            drive(1'b1, 1'b1, coord_t'(i), coord_t'(1), 1'b0, 1'b0);
        @(posedge lcd_pclk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_stream", 64'({pix.pixel_valid, pix.pixel_data, pix.pixel_x, pix.pixel_y,
                                    pix.frame_start, pix.line_end}), 64'd0);
        meas("midrst", 0, 0, 1'b0);
        exp_q.delete();
        repeat (3) drive(1'b1, 1'b0, COORD_ZERO, COORD_ZERO, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (9) drive(1'b1, 1'b0, COORD_ZERO, COORD_ZERO, 1'b0, 1'b0);
        idle(HBL);
        for (int l = 2; l < 4; l++) begin
            line(24, l, 1'b0, 1'b0);
            idle(HBL);
        end
        idle(2 * 48);
        frame(24, 4, 1'b1);  meas("post_rst", 24, 4, 1'b0);

`ifdef LCD_RX_CHECKSUM_EN
        const_one = 1'b1;
        frame(24, 4, 1'b1);
        const_one = 1'b0;
        check("frame_sum", 64'(frame_sum), 64'd96);
`endif

        repeat (5) @(negedge lcd_pclk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
